// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for a processor memory stage.
//
// Serves a word-addressed data RAM plus a small block of memory-mapped registers:
//   0xFFFFFF00 CYCLE   free-running cycle counter (write loads it)
//   0xFFFFFF01 TXDATA  write pushes data[7:0] into the TX FIFO, reads return 0
//   0xFFFFFF02 STATUS  {14'b0, count[15:0], full, empty}
//   0xFFFFFF03 OVFL    saturating count of bytes dropped on a full FIFO (write clears)
// Every read is registered (1-cycle latency) and read-first against a same-edge write.
// Unmapped reads return 0 and unmapped writes are ignored.
//
// Optional feature: define DMEM_CYCLE_COUNTER_EN to build the CYCLE counter. Without it
// CYCLE reads 0, writes to it are ignored and no counter register exists.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_ni         asynchronous active-low reset (RAM contents are not reset)
//   address_dmem_i word address
//   data_i         store data
//   wren_i         store enable
//   q_dmem_o       registered load data
//   tx_data_o      head byte of the TX FIFO, 0 while empty
//   tx_valid_o     TX FIFO non-empty
//   tx_ready_i     downstream sink accepts tx_data_o (pop when valid and ready)
module dmem_responder #(
    parameter int unsigned RAM_DEPTH  = 4096,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] address_dmem_i,
    input  logic [31:0] data_i,
    input  logic        wren_i,
    output logic [31:0] q_dmem_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i
);

    localparam int unsigned RamAw = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW  = PtrW + 1;

    localparam logic [31:0] AddrCycle  = 32'hFFFF_FF00;
    localparam logic [31:0] AddrTxData = 32'hFFFF_FF01;
    localparam logic [31:0] AddrStatus = 32'hFFFF_FF02;
    localparam logic [31:0] AddrOvfl   = 32'hFFFF_FF03;

    // ---------------------------------------------------------------- decode
    logic             ram_hit;
    logic [RamAw-1:0] ram_idx;
    logic             txdata_wr;
    logic             ovfl_wr;

    assign ram_hit   = address_dmem_i < 32'(RAM_DEPTH);
    assign ram_idx   = address_dmem_i[RamAw-1:0];
    assign txdata_wr = wren_i && (address_dmem_i == AddrTxData);
    assign ovfl_wr   = wren_i && (address_dmem_i == AddrOvfl);

    // ---------------------------------------------------------------- data RAM
    logic [31:0] ram_q [RAM_DEPTH];

    always_ff @(posedge clk_i) begin
        if (wren_i && ram_hit) begin
            ram_q[ram_idx] <= data_i;
        end
    end

    // ---------------------------------------------------------------- TX FIFO
    logic [7:0]      fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            overflow;

    assign fifo_full  = count_q == CntW'(FIFO_DEPTH);
    assign fifo_empty = count_q == '0;
    // Fullness is judged on the pre-edge count, so a same-edge pop never makes room.
    assign push       = txdata_wr && !fifo_full;
    assign overflow   = txdata_wr && fifo_full;
    assign pop        = tx_valid_o && tx_ready_i;

    always_comb begin
        wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + PtrW'(1) : rptr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wptr_q] <= data_i[7:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // No fall-through: valid follows the registered count only.
    assign tx_valid_o = !fifo_empty;
    assign tx_data_o  = fifo_empty ? 8'h00 : fifo_q[rptr_q];

    // ---------------------------------------------------------------- OVFL counter
    logic [31:0] ovfl_q, ovfl_d;

    always_comb begin
        ovfl_d = ovfl_q;
        if (ovfl_wr) begin
            ovfl_d = '0;
        end else if (overflow && (ovfl_q != 32'hFFFF_FFFF)) begin
            ovfl_d = ovfl_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovfl_q <= '0;
        end else begin
            ovfl_q <= ovfl_d;
        end
    end

    // ---------------------------------------------------------------- CYCLE counter
    logic [31:0] cycle_rd;

`ifdef DMEM_CYCLE_COUNTER_EN
    logic        cycle_wr;
    logic [31:0] cycle_q, cycle_d;

    assign cycle_wr = wren_i && (address_dmem_i == AddrCycle);
    assign cycle_d  = cycle_wr ? data_i : cycle_q + 32'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    assign cycle_rd = cycle_q;
`else
    assign cycle_rd = '0;
`endif

    // ---------------------------------------------------------------- read path
    logic [15:0] status_cnt;
    logic [31:0] rdata;
    logic [31:0] q_dmem_q;

    assign status_cnt = 16'(count_q);

    // All sources are pre-edge values, which makes reads read-first.
    always_comb begin
        rdata = '0;
        if (ram_hit) begin
            rdata = ram_q[ram_idx];
        end else begin
            case (address_dmem_i)
                AddrCycle:  rdata = cycle_rd;
                AddrStatus: rdata = {14'd0, status_cnt, fifo_full, fifo_empty};
                AddrOvfl:   rdata = ovfl_q;
                default:    rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_dmem_q <= '0;
        end else begin
            q_dmem_q <= rdata;
        end
    end

    assign q_dmem_o = q_dmem_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: expected load data is pushed to a queue when a
// read is driven and compared once the registered result appears; a byte queue models
// the TX FIFO and the OVFL counter.
module tb_dmem_responder;

    localparam int unsigned   FD         = 8;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF_FF00;
    localparam logic [31:0] A_TXDATA = 32'hFFFF_FF01;
    localparam logic [31:0] A_STATUS = 32'hFFFF_FF02;
    localparam logic [31:0] A_OVFL   = 32'hFFFF_FF03;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] address;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        rdy;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    logic [31:0] obs_q [$];
    string       nm_q  [$];
    logic [7:0]  txq   [$];
    logic [31:0] ovfl_m = '0;

    dmem_responder #(
        .RAM_DEPTH (4096),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .address_dmem_i(address),
        .data_i        (data),
        .wren_i        (wren),
        .q_dmem_o      (q_dmem),
        .tx_data_o     (tx_data),
        .tx_valid_o    (tx_valid),
        .tx_ready_i    (rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] status_exp();
        int n;
        n = txq.size();
        return {14'd0, 16'(n), n == FD, n == 0};
    endfunction

    // Drive one cycle and advance the FIFO/OVFL model with the pre-edge state.
    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we);
        bit full_m;
        bit pop_m;
        address = a;
        data    = d;
        wren    = we;
        full_m  = txq.size() == FD;
        pop_m   = rdy && (txq.size() != 0);
        if (pop_m) void'(txq.pop_front());
        if (we && a == A_TXDATA) begin
            if (full_m) begin
                if (ovfl_m != 32'hFFFF_FFFF) ovfl_m++;
            end else begin
                txq.push_back(d[7:0]);
            end
        end
        if (we && a == A_OVFL) ovfl_m = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic we,
                      input logic [31:0] e, input string nm);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        cyc(a, d, we);
        obs_q.push_back(q_dmem);
    endtask

    task automatic test_reset();
        checks++;
        if (q_dmem !== 32'h0) begin
            errors++; $display("FAIL reset_q_dmem: got %h expected 0", q_dmem);
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid);
        end
        checks++;
        if (tx_data !== 8'h00) begin
            errors++; $display("FAIL reset_tx_data: got %h expected 0", tx_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
`ifdef DMEM_CYCLE_COUNTER_EN
        rd(A_CYCLE, 0, 0, 32'd0, "cycle_first_edge");
        rd(A_CYCLE, 0, 0, 32'd1, "cycle_second_edge");
`else
        rd(A_CYCLE, 0, 0, 32'd0, "cycle_first_edge");
        rd(A_CYCLE, 0, 0, 32'd0, "cycle_second_edge");
`endif
        while (exp_q.size() != 0) begin
            logic [31:0] e, o;
            string n;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, o, e); end
        end
    endtask

    task automatic test_ram();
        cyc(32'd5, 32'hDEAD_BEEF, 1'b1);
        rd(32'd5, 0, 0, 32'hDEAD_BEEF, "ram_read_5");
        rd(32'd4096, 0, 0, 32'h0, "ram_read_depth");
        cyc(32'd4101, 32'h1234_5678, 1'b1);
        rd(32'd5, 0, 0, 32'hDEAD_BEEF, "ram_no_alias");
        rd(32'hFFFF_FF10, 0, 0, 32'h0, "unmapped_read");
        while (exp_q.size() != 0) begin
            logic [31:0] e, o;
            string n;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, o, e); end
        end
    endtask

    task automatic test_read_during_write();
        cyc(32'd7, 32'h11, 1'b1);
        rd(32'd7, 32'h22, 1'b1, 32'h11, "rdw_old_value");
        rd(32'd7, 0, 0, 32'h22, "rdw_new_value");
        while (exp_q.size() != 0) begin
            logic [31:0] e, o;
            string n;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, o, e); end
        end
    endtask

    task automatic test_fifo_fill();
        rdy = 1'b0;
        cyc(A_OVFL, 0, 1'b1);
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++; $display("FAIL fill_empty_valid: got %b expected 0", tx_valid);
        end
        for (int i = 0; i < 9; i++) begin
            cyc(A_TXDATA, 32'h41 + i, 1'b1);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== txq[0]) begin
                errors++;
                $display("FAIL fill_head_%0d: got valid=%b data=%h expected valid=1 data=%h",
                         i, tx_valid, tx_data, txq[0]);
            end
        end
        rd(A_STATUS, 0, 0, status_exp(), "fill_status");
        rd(A_OVFL, 0, 0, ovfl_m, "fill_ovfl");
        rd(A_TXDATA, 0, 0, 32'h0, "txdata_read");
        while (exp_q.size() != 0) begin
            logic [31:0] e, o;
            string n;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, o, e); end
        end
    endtask

    task automatic test_fifo_drain();
        rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] e;
            e = (txq.size() != 0) ? txq[0] : 8'h00;
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== e) begin
                errors++;
                $display("FAIL drain_byte_%0d: got valid=%b data=%h expected valid=1 data=%h",
                         i, tx_valid, tx_data, e);
            end
            cyc(32'd0, 0, 1'b0);
        end
        rdy = 1'b0;
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL drain_empty: got valid=%b data=%h expected valid=0 data=00",
                     tx_valid, tx_data);
        end
        rd(A_STATUS, 0, 0, status_exp(), "drain_status");
        while (exp_q.size() != 0) begin
            logic [31:0] e, o;
            string n;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, o, e); end
        end
    endtask

    task automatic test_back_to_back();
        int budget;
        rdy = 1'b0;
        cyc(A_TXDATA, 32'h60, 1'b1);
        cyc(A_TXDATA, 32'h61, 1'b1);
        rdy = 1'b1;
        cyc(A_TXDATA, 32'h62, 1'b1);
        rdy = 1'b0;
        checks++;
        if (tx_data !== txq[0]) begin
            errors++; $display("FAIL pushpop_head: got %h expected %h", tx_data, txq[0]);
        end
        rd(A_STATUS, 0, 0, status_exp(), "pushpop_status");
        for (int i = 0; i < 6; i++) cyc(A_TXDATA, 32'h63 + i, 1'b1);
        rd(A_STATUS, 0, 0, status_exp(), "refill_status");
        rdy = 1'b1;
        cyc(A_TXDATA, 32'h69, 1'b1);
        rdy = 1'b0;
        rd(A_STATUS, 0, 0, status_exp(), "full_pushpop_status");
        rd(A_OVFL, 0, 0, ovfl_m, "full_pushpop_ovfl");
        cyc(A_OVFL, 0, 1'b1);
        rd(A_OVFL, 0, 0, ovfl_m, "ovfl_cleared");
        while (exp_q.size() != 0) begin
            logic [31:0] e, o;
            string n;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, o, e); end
        end
        // Drain what is left, checking order across the pointer wrap.
        rdy = 1'b1;
        budget = 16;
        while (txq.size() != 0 && budget > 0) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== txq[0]) begin
                errors++;
                $display("FAIL wrap_drain: got valid=%b data=%h expected valid=1 data=%h",
                         tx_valid, tx_data, txq[0]);
            end
            cyc(32'd0, 0, 1'b0);
            budget--;
        end
        rdy = 1'b0;
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_drain_done: got valid=%b expected 0", tx_valid);
        end
    endtask

    task automatic test_cycle();
        cyc(A_CYCLE, 32'hFFFF_FFFE, 1'b1);
`ifdef DMEM_CYCLE_COUNTER_EN
        rd(A_CYCLE, 0, 0, 32'hFFFF_FFFE, "cycle_loaded");
        rd(A_CYCLE, 0, 0, 32'hFFFF_FFFF, "cycle_max");
        rd(A_CYCLE, 0, 0, 32'h0000_0000, "cycle_wrap");
`else
        rd(A_CYCLE, 0, 0, 32'h0, "cycle_loaded");
        rd(A_CYCLE, 0, 0, 32'h0, "cycle_max");
        rd(A_CYCLE, 0, 0, 32'h0, "cycle_wrap");
`endif
        while (exp_q.size() != 0) begin
            logic [31:0] e, o;
            string n;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, o, e); end
        end
    endtask

    task automatic test_reset_mid();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) cyc(A_TXDATA, 32'h70 + i, 1'b1);
        rd(A_STATUS, 0, 0, status_exp(), "pre_reset_status");
        while (exp_q.size() != 0) begin
            logic [31:0] e, o;
            string n;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, o, e); end
        end
        checks++;
        if (tx_valid !== 1'b1) begin
            errors++; $display("FAIL pre_reset_valid: got %b expected 1", tx_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        txq.delete();
        ovfl_m = '0;
        checks++;
        if (q_dmem !== 32'h0 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got q=%h valid=%b data=%h expected q=0 valid=0 data=00",
                     q_dmem, tx_valid, tx_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd(A_STATUS, 0, 0, status_exp(), "post_reset_status");
        rd(32'd5, 0, 0, 32'hDEAD_BEEF, "ram_kept_over_reset");
        while (exp_q.size() != 0) begin
            logic [31:0] e, o;
            string n;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, o, e); end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        address = '0;
        data    = '0;
        wren    = 1'b0;
        rdy     = 1'b0;
        #12;
        test_reset();
        test_ram();
        test_read_during_write();
        test_fifo_fill();
        test_fifo_drain();
        test_back_to_back();
        test_cycle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
